// File: rtl/oam_dma_writer.sv
// oam_dma_writer: commits OAM DMA bytes into the OAM RAM and arbitrates the
// OAM port between DMA writes, PPU sprite-scan reads and CPU accesses.
// The OAM macro reads combinationally. A registered CPU read result is
// therefore valid one cycle after the read strobe.
module oam_dma_writer #(
   parameter int OAM_BYTES = 160
) (
   input  logic        clk1,
   input  logic        reset,
   input  logic        dma_run,
   input  logic        dma_step,
   input  logic [7:0]  dma_a_lo,
   input  logic [7:0]  dma_d,
   input  logic        ppu_req,
   input  logic [6:0]  ppu_a,
   input  logic        cpu_oam_sel,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_a,
   input  logic [7:0]  cpu_d,
   input  logic [15:0] oam_rdata,
   output logic [6:0]  oam_a,
   output logic        oam_we_lo,
   output logic        oam_we_hi,
   output logic [7:0]  oam_wd,
   output logic        oam_re,
   output logic        ppu_gnt,
   output logic [7:0]  cpu_rdata,
   output logic [7:0]  dma_count,
   output logic        dma_done,
   output logic        seq_err
);

   localparam logic [7:0] LIMIT = 8'(OAM_BYTES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_HOLD,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        pend_q, pend_d;
   logic [7:0]  pend_addr_q, pend_addr_d;
   logic [7:0]  pend_data_q, pend_data_d;
   logic [7:0]  count_q, count_d;
   logic        seq_err_q, seq_err_d;
   logic [7:0]  cpu_rdata_q, cpu_rdata_d;

   logic        dma_wr;
   logic        step_v;
   logic        arm;
   logic [7:0]  exp_addr;
   logic [7:0]  count_inc;
   logic        cpu_blocked;
   logic        cpu_in_range;
   logic        cpu_wr_ok;
   logic        cpu_rd_ok;

   // Qualify DMA steps and compute the sequence bookkeeping for this cycle.
   always_comb begin
      // Reset gates the pending write so an aborted transfer never strobes OAM.
      dma_wr       = pend_q & ~reset;
      step_v       = dma_step & dma_run & ((state_q == S_ARMED) || (state_q == S_HOLD));
      arm          = (state_q == S_IDLE) & dma_run;
      exp_addr     = count_q + {7'd0, pend_q};
      count_inc    = count_q + 8'd1;
      cpu_blocked  = dma_run | ppu_req | pend_q;
      cpu_in_range = cpu_a < LIMIT;
      cpu_wr_ok    = cpu_oam_sel & cpu_wr & ~cpu_blocked & cpu_in_range & ~reset;
      cpu_rd_ok    = cpu_oam_sel & cpu_rd & ~cpu_blocked & cpu_in_range & ~reset;
   end

   // Transfer FSM: next state and the done pulse.
   always_comb begin
      // NOTE: every signal written here gets a default first, otherwise a path
      // that skips the assignment would infer a latch.
      state_d  = state_q;
      dma_done = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (dma_run) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (!dma_run)      state_d = S_IDLE;
            else if (dma_step) state_d = S_HOLD;
         end
         S_HOLD: begin
            // The pending write completes in this cycle whatever dma_run does.
            if (pend_q && (count_inc == LIMIT)) state_d = S_DONE;
            else if (!dma_run)                  state_d = S_IDLE;
            else if (dma_step)                  state_d = S_HOLD;
            else                                state_d = S_ARMED;
         end
         S_DONE: begin
            dma_done = ~reset;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the hold register, counter, error flag and CPU read data.
   always_comb begin
      pend_d      = step_v & (dma_a_lo < LIMIT);
      pend_addr_d = step_v ? dma_a_lo : pend_addr_q;
      pend_data_d = step_v ? dma_d : pend_data_q;

      count_d = count_q;
      if (arm)         count_d = 8'd0;
      else if (dma_wr) count_d = count_inc;

      seq_err_d = seq_err_q;
      if (arm)
         seq_err_d = 1'b0;
      else if (step_v && ((dma_a_lo >= LIMIT) || (dma_a_lo != exp_addr)))
         seq_err_d = 1'b1;

      cpu_rdata_d = cpu_rdata_q;
      if (cpu_oam_sel && cpu_rd) begin
         if (cpu_blocked)       cpu_rdata_d = 8'hFF;
         else if (!cpu_in_range) cpu_rdata_d = 8'h00;
         else if (cpu_a[0])     cpu_rdata_d = oam_rdata[15:8];
         else                   cpu_rdata_d = oam_rdata[7:0];
      end
   end

   // OAM port arbitration: DMA write, then PPU read, then CPU access.
   always_comb begin
      oam_a     = 7'd0;
      oam_we_lo = 1'b0;
      oam_we_hi = 1'b0;
      oam_wd    = 8'd0;
      oam_re    = 1'b0;
      ppu_gnt   = 1'b0;
      if (dma_wr) begin
         oam_a     = pend_addr_q[7:1];
         oam_we_lo = ~pend_addr_q[0];
         oam_we_hi = pend_addr_q[0];
         oam_wd    = pend_data_q;
      end else if (ppu_req && !reset) begin
         oam_a   = ppu_a;
         oam_re  = 1'b1;
         ppu_gnt = 1'b1;
      end else if (cpu_wr_ok) begin
         oam_a     = cpu_a[7:1];
         oam_we_lo = ~cpu_a[0];
         oam_we_hi = cpu_a[0];
         oam_wd    = cpu_d;
      end else if (cpu_rd_ok) begin
         oam_a  = cpu_a[7:1];
         oam_re = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk1) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q     <= S_IDLE;
         pend_q      <= 1'b0;
         pend_addr_q <= 8'd0;
         pend_data_q <= 8'd0;
         count_q     <= 8'd0;
         seq_err_q   <= 1'b0;
         cpu_rdata_q <= 8'hFF;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         count_q     <= count_d;
         seq_err_q   <= seq_err_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   assign dma_count = count_q;
   assign seq_err   = seq_err_q;
   assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_oam_dma_writer.sv
// Directed testbench for oam_dma_writer with a combinational-read OAM model.
module tb_oam_dma_writer;

   logic        clk1 = 1'b0;
   logic        reset;
   logic        dma_run, dma_step;
   logic [7:0]  dma_a_lo, dma_d;
   logic        ppu_req;
   logic [6:0]  ppu_a;
   logic        cpu_oam_sel, cpu_rd, cpu_wr;
   logic [7:0]  cpu_a, cpu_d;
   logic [15:0] oam_rdata;
   logic [6:0]  oam_a;
   logic        oam_we_lo, oam_we_hi;
   logic [7:0]  oam_wd;
   logic        oam_re, ppu_gnt;
   logic [7:0]  cpu_rdata, dma_count;
   logic        dma_done, seq_err;

   logic [7:0]  oam_mem [0:255];
   logic [7:0]  exp_mem [0:255];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_cnt = 0;

   oam_dma_writer #(.OAM_BYTES(160)) dut (
      .clk1(clk1), .reset(reset),
      .dma_run(dma_run), .dma_step(dma_step), .dma_a_lo(dma_a_lo), .dma_d(dma_d),
      .ppu_req(ppu_req), .ppu_a(ppu_a),
      .cpu_oam_sel(cpu_oam_sel), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
      .cpu_a(cpu_a), .cpu_d(cpu_d),
      .oam_rdata(oam_rdata), .oam_a(oam_a),
      .oam_we_lo(oam_we_lo), .oam_we_hi(oam_we_hi), .oam_wd(oam_wd),
      .oam_re(oam_re), .ppu_gnt(ppu_gnt), .cpu_rdata(cpu_rdata),
      .dma_count(dma_count), .dma_done(dma_done), .seq_err(seq_err)
   );

   always #5 clk1 = ~clk1;

   // OAM RAM model: byte-lane writes on the clock edge, combinational read.
   always @(posedge clk1) begin
      if (oam_we_lo) oam_mem[{oam_a, 1'b0}] <= oam_wd;
      if (oam_we_hi) oam_mem[{oam_a, 1'b1}] <= oam_wd;
   end
   assign oam_rdata = {oam_mem[{oam_a, 1'b1}], oam_mem[{oam_a, 1'b0}]};

   always @(negedge clk1) if (dma_done) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; checks follow 3 ns later.
   task automatic next_cycle();
      @(posedge clk1);
      #1;
   endtask

   // One DMA step cycle, returning in the following (write) cycle.
   task automatic dma_byte(input logic [7:0] a, input logic [7:0] d);
      next_cycle();
      dma_step = 1'b1; dma_a_lo = a; dma_d = d;
      next_cycle();
      dma_step = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int mism;
      reset = 1'b1; dma_run = 1'b0; dma_step = 1'b0; dma_a_lo = 8'd0; dma_d = 8'd0;
      ppu_req = 1'b0; ppu_a = 7'd0; cpu_oam_sel = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
      cpu_a = 8'd0; cpu_d = 8'd0;
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'd0;

      // Reset state.
      repeat (3) next_cycle();
      #3;
      check("rst_we",    {oam_we_hi, oam_we_lo}, 0);
      check("rst_re",    {oam_re, ppu_gnt}, 0);
      check("rst_done",  {dma_done, seq_err}, 0);
      check("rst_a_wd",  {oam_a, oam_wd}, 0);
      check("rst_count", dma_count, 0);
      check("rst_rdata", cpu_rdata, 8'hFF);

      // Full 160-byte transfer, one step every 4 cycles.
      next_cycle();
      reset = 1'b0;
      next_cycle();
      dma_run = 1'b1;
      for (int i = 0; i < 160; i++) begin
         logic [7:0] a;
         a = 8'(i);
         exp_mem[i] = a ^ 8'h5A;
         dma_byte(a, a ^ 8'h5A);
         #3;
         check("full_we_lo", oam_we_lo, !a[0]);
         check("full_we_hi", oam_we_hi, a[0]);
         check("full_a",     oam_a, a[7:1]);
         check("full_wd",    oam_wd, a ^ 8'h5A);
         check("full_done_early", dma_done, 0);
         if (i == 159) begin
            next_cycle();
            dma_run = 1'b0;
            #3;
            check("full_done",  dma_done, 1);
            check("full_count", dma_count, 160);
            next_cycle();
            #3;
            check("full_done_end", dma_done, 0);
            check("full_count_end", dma_count, 160);
            check("full_seq_err", seq_err, 0);
         end else begin
            next_cycle();
            #3;
            check("full_count_inc", dma_count, i + 1);
            check("full_idle_we", {oam_we_hi, oam_we_lo}, 0);
            next_cycle();
         end
      end
      mism = 0;
      for (int i = 0; i < 160; i++) if (oam_mem[i] !== exp_mem[i]) mism++;
      check("full_oam_bytes", mism, 0);
      check("full_done_pulses", done_cnt, 1);

      // Back-to-back steps at addresses 0, 1, 2.
      next_cycle();
      dma_run = 1'b1;
      next_cycle();
      dma_step = 1'b1; dma_a_lo = 8'd0; dma_d = 8'hC0;
      #3;
      check("b2b_count0", dma_count, 0);
      next_cycle();
      dma_a_lo = 8'd1; dma_d = 8'hC1;
      #3;
      check("b2b_w0", {oam_we_hi, oam_we_lo, oam_a, oam_wd}, {2'b01, 7'd0, 8'hC0});
      next_cycle();
      dma_a_lo = 8'd2; dma_d = 8'hC2;
      #3;
      check("b2b_w1", {oam_we_hi, oam_we_lo, oam_a, oam_wd}, {2'b10, 7'd0, 8'hC1});
      next_cycle();
      dma_step = 1'b0;
      #3;
      check("b2b_w2", {oam_we_hi, oam_we_lo, oam_a, oam_wd}, {2'b01, 7'd1, 8'hC2});
      check("b2b_count2", dma_count, 2);
      exp_mem[0] = 8'hC0; exp_mem[1] = 8'hC1; exp_mem[2] = 8'hC2;
      next_cycle();
      #3;
      check("b2b_count3", dma_count, 3);
      check("b2b_seq_ok", seq_err, 0);

      // Out-of-range step: no write, error set, count held.
      dma_byte(8'hA0, 8'hEE);
      #3;
      check("oor_no_we", {oam_we_hi, oam_we_lo}, 0);
      check("oor_seq_err", seq_err, 1);
      next_cycle();
      #3;
      check("oor_count", dma_count, 3);
      dma_run = 1'b0;
      next_cycle();
      #3;
      check("seq_sticky", seq_err, 1);
      next_cycle();
      dma_run = 1'b1;
      next_cycle();
      #3;
      check("arm_clears_err", seq_err, 0);
      check("arm_clears_cnt", dma_count, 0);

      // Mismatched address: write still performed, error set.
      dma_byte(8'd0, 8'hC0);
      dma_byte(8'd1, 8'hC1);
      dma_byte(8'd2, 8'hC2);
      next_cycle();
      #3;
      check("mis_count3", dma_count, 3);
      check("mis_err_before", seq_err, 0);
      dma_byte(8'd5, 8'h77);
      exp_mem[5] = 8'h77;
      #3;
      check("mis_write", {oam_we_hi, oam_we_lo, oam_a, oam_wd}, {2'b10, 7'd2, 8'h77});
      next_cycle();
      #3;
      check("mis_seq_err", seq_err, 1);
      check("mis_count4", dma_count, 4);

      // CPU access during DMA is dropped and reads 0xFF.
      next_cycle();
      cpu_oam_sel = 1'b1; cpu_wr = 1'b1; cpu_a = 8'h10; cpu_d = 8'h33;
      #3;
      check("cpu_busy_no_we", {oam_we_hi, oam_we_lo}, 0);
      next_cycle();
      cpu_wr = 1'b0; cpu_rd = 1'b1;
      next_cycle();
      cpu_rd = 1'b0; cpu_oam_sel = 1'b0; dma_run = 1'b0;
      #3;
      check("cpu_busy_rd", cpu_rdata, 8'hFF);
      check("cpu_busy_mem", oam_mem[16], 8'h4A);

      // CPU access with the port free.
      next_cycle();
      cpu_oam_sel = 1'b1; cpu_wr = 1'b1; cpu_a = 8'h10; cpu_d = 8'h33;
      #3;
      check("cpu_wr", {oam_we_hi, oam_we_lo, oam_a, oam_wd}, {2'b01, 7'h08, 8'h33});
      exp_mem[16] = 8'h33;
      next_cycle();
      cpu_wr = 1'b0; cpu_rd = 1'b1;
      #3;
      check("cpu_rd_re", {oam_re, oam_a}, {1'b1, 7'h08});
      next_cycle();
      cpu_a = 8'h11;
      #3;
      check("cpu_rd_33", cpu_rdata, 8'h33);
      next_cycle();
      cpu_a = 8'hA0;
      #3;
      check("cpu_rd_hi_lane", cpu_rdata, 8'h4B);
      next_cycle();
      cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_a = 8'hA5; cpu_d = 8'h55;
      #3;
      check("cpu_rd_oor", cpu_rdata, 8'h00);
      check("cpu_wr_oor", {oam_we_hi, oam_we_lo}, 0);
      next_cycle();
      cpu_wr = 1'b0; cpu_oam_sel = 1'b0;
      #3;
      check("cpu_rd_hold", cpu_rdata, 8'h00);

      // PPU request held across a DMA write cycle.
      next_cycle();
      dma_run = 1'b1;
      next_cycle();
      dma_step = 1'b1; dma_a_lo = 8'd0; dma_d = 8'hC0;
      ppu_req = 1'b1; ppu_a = 7'h2B;
      #3;
      check("ppu_gnt_free", ppu_gnt, 1);
      next_cycle();
      dma_step = 1'b0;
      #3;
      check("ppu_blocked", {ppu_gnt, oam_re, oam_we_lo, oam_a}, {3'b001, 7'd0});
      next_cycle();
      #3;
      check("ppu_gnt_next", {ppu_gnt, oam_re, oam_a}, {2'b11, 7'h2B});

      // Reset one cycle after a step discards the pending write.
      next_cycle();
      ppu_req = 1'b0;
      dma_step = 1'b1; dma_a_lo = 8'd1; dma_d = 8'h99;
      next_cycle();
      dma_step = 1'b0; reset = 1'b1;
      #3;
      check("rst_abort_we", {oam_we_hi, oam_we_lo}, 0);
      next_cycle();
      #3;
      check("rst2_we_re", {oam_we_hi, oam_we_lo, oam_re, ppu_gnt}, 0);
      check("rst2_flags", {dma_done, seq_err}, 0);
      check("rst2_a_wd",  {oam_a, oam_wd}, 0);
      check("rst2_count", dma_count, 0);
      check("rst2_rdata", cpu_rdata, 8'hFF);
      next_cycle();
      reset = 1'b0; dma_run = 1'b0;
      #3;
      check("rst_after_we", {oam_we_hi, oam_we_lo}, 0);
      check("rst_mem1", oam_mem[1], 8'hC1);
      next_cycle();
      dma_run = 1'b1;
      next_cycle();
      #3;
      check("restart_count0", dma_count, 0);
      dma_byte(8'd0, 8'hC0);
      #3;
      check("restart_we", {oam_we_hi, oam_we_lo, oam_a}, {2'b01, 7'd0});
      next_cycle();
      #3;
      check("restart_count1", dma_count, 1);
      check("restart_seq", seq_err, 0);
      dma_run = 1'b0;
      next_cycle();

      // Final OAM image.
      mism = 0;
      for (int i = 0; i < 160; i++) if (oam_mem[i] !== exp_mem[i]) mism++;
      check("final_oam_bytes", mism, 0);
      check("final_done_pulses", done_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
